mmio_hub: RTL

MMIO_HUB -- requirements
Module: mmio_hub

---
 rtl/mmio_hub.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_hub.sv
// rtl/mmio_hub.sv - CPU memory-mapped hub: RAM/ROM/VRAM decode plus debounced-button,
// sticky-flag, cycle-counter and error-counter IO registers.
module mmio_hub #(
  parameter int DW              = 32,
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAM_AW          = 10,
  parameter int ROM_AW          = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   read_enable,
  input  logic                   write_enable,
  input  logic [31:0]            data_address,
  input  logic [DW-1:0]          data_input,
  output logic [DW-1:0]          data_output,
  output logic                   read_valid,
  output logic                   decode_error,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [RAM_AW-1:0]      ram_address,
  output logic                   ram_we,
  output logic [DW-1:0]          ram_data,
  input  logic [DW-1:0]          ram_read,
  output logic [ROM_AW-1:0]      rom_address,
  input  logic [DW-1:0]          rom_read,
  output logic [ROM_AW-1:0]      vram_address,
  output logic                   vram_we,
  output logic [DW-1:0]          vram_data
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_ROM  = 2'd1,
    REG_VRAM = 2'd2,
    REG_IO   = 2'd3
  } region_e;

  logic                   r_rst_sync;
  logic                   r_rd_valid;
  region_e                r_sel;
  logic [DW-1:0]          r_io_data;
  logic [DW-1:0]          r_dout;
  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;
  logic [NUM_BUTTONS-1:0] r_level;
  logic [NUM_BUTTONS-1:0] r_flags;
  logic [CW-1:0]          r_db_cnt [NUM_BUTTONS];
  logic [31:0]            r_cycles;
  logic [7:0]             r_err_cnt;

  region_e                w_region;
  logic [31:0]            w_idx;
  logic                   w_req;
  logic                   w_bad;
  logic                   w_err;
  logic                   w_rd;
  logic                   w_wr;
  logic                   w_io_wr;
  logic                   w_clr_err;
  logic [NUM_BUTTONS-1:0] w_clr_flags;
  logic [NUM_BUTTONS-1:0] w_level_nxt;
  logic [NUM_BUTTONS-1:0] w_rise;
  logic [DW-1:0]          w_io_rdata;

  // Reset release is re-timed so the first request lands on the second edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 1'b0;
    else        r_rst_sync <= 1'b1;
  end

  assign w_region = region_e'(data_address[17:16]);
  assign w_idx    = {18'd0, data_address[15:2]};

  always_comb begin
    w_req = r_rst_sync & (read_enable | write_enable);
    w_bad = 1'b0;
    if (data_address[31:18] != '0 || data_address[1:0] != 2'b00 || (read_enable && write_enable))
      w_bad = 1'b1;
    case (w_region)
      REG_RAM:  if (w_idx >= (32'd1 << RAM_AW)) w_bad = 1'b1;
      REG_ROM:  if (write_enable || w_idx >= (32'd1 << ROM_AW)) w_bad = 1'b1;
      REG_VRAM: if (read_enable || w_idx >= (32'd1 << ROM_AW)) w_bad = 1'b1;
      REG_IO: begin
        if (w_idx >= 32'd4) w_bad = 1'b1;
        else if (write_enable && !w_idx[0]) w_bad = 1'b1;
      end
    endcase
  end

  assign w_err       = w_req & w_bad;
  assign w_rd        = w_req & ~w_bad & read_enable;
  assign w_wr        = w_req & ~w_bad & write_enable;
  assign w_io_wr     = w_wr && (w_region == REG_IO);
  assign w_clr_err   = w_io_wr && (w_idx[1:0] == 2'd3);
  assign w_clr_flags = (w_io_wr && w_idx[1:0] == 2'd1) ? data_input[NUM_BUTTONS-1:0] : '0;

  assign decode_error = w_err;
  assign ram_we       = w_wr && (w_region == REG_RAM);
  assign vram_we      = w_wr && (w_region == REG_VRAM);
  assign ram_address  = w_idx[RAM_AW-1:0];
  assign rom_address  = w_idx[ROM_AW-1:0];
  assign vram_address = w_idx[ROM_AW-1:0];
  assign ram_data     = data_input;
  assign vram_data    = data_input;

  always_comb begin
    w_level_nxt = r_level;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (r_sync2[i] != r_level[i] && r_db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1))
        w_level_nxt[i] = ~r_level[i];
    end
  end

  assign w_rise = w_level_nxt & ~r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_flags <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      // A new rise outranks a same-cycle write-1-clear.
      r_flags <= (r_flags & ~w_clr_flags) | w_rise;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (r_sync2[i] == r_level[i] || w_level_nxt[i] != r_level[i]) r_db_cnt[i] <= '0;
        else                                                          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_clr_err)                        r_err_cnt <= {7'd0, w_err};
      else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  always_comb begin
    w_io_rdata = '0;
    case (w_idx[1:0])
      2'd0: w_io_rdata = DW'(r_level);
      2'd1: w_io_rdata = DW'(r_flags);
      2'd2: w_io_rdata = DW'(r_cycles);
      2'd3: w_io_rdata = DW'(r_err_cnt);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_sel      <= REG_RAM;
      r_io_data  <= '0;
      r_dout     <= '0;
    end else begin
      r_rd_valid <= w_rd;
      r_dout     <= data_output;
      if (w_rd) r_sel <= w_region;
      if (w_rd && w_region == REG_IO) r_io_data <= w_io_rdata;
    end
  end

  always_comb begin
    data_output = r_dout;
    if (r_rd_valid) begin
      case (r_sel)
        REG_RAM: data_output = ram_read;
        REG_ROM: data_output = rom_read;
        default: data_output = r_io_data;
      endcase
    end
  end

  assign read_valid = r_rd_valid;

endmodule
